// File: rtl/csa_pkg.sv
// ---------------------------------------------------------------------------
// csa_pkg
// Shared definitions for the pipelined carry-save adder tree:
//   DADDA_H      - Dadda height sequence used to pick each level's target height
//   stage_tag_t  - sideband tags that travel with every pipeline stage
//   csa_levels   - number of 3:2 levels needed to reduce n operands to two
//   dadda_height - operand count remaining after a given number of levels
// ---------------------------------------------------------------------------
package csa_pkg;

    localparam int DADDA_N = 7;
    localparam int DADDA_H [DADDA_N] = '{2, 3, 4, 6, 9, 13, 19};

    typedef struct packed {
        logic valid;
        logic acc;
        logic clr;
    } stage_tag_t;

    // Each Dadda height strictly below n costs one reduction level.
    function automatic int csa_levels(input int n);
        int lv;
        lv = 0;
        for (int i = 0; i < DADDA_N; i++) begin
            if (DADDA_H[i] < n) begin
                lv++;
            end
        end
        return lv;
    endfunction

    // Height after 'lvl' levels: each level drops to the largest Dadda
    // height strictly below the current one.
    function automatic int dadda_height(input int n, input int lvl);
        int h;
        int t;
        h = n;
        for (int l = 0; l < lvl; l++) begin
            t = 2;
            for (int i = 0; i < DADDA_N; i++) begin
                if (DADDA_H[i] < h) begin
                    t = DADDA_H[i];
                end
            end
            h = t;
        end
        return h;
    endfunction

endpackage

// File: rtl/csa_row_3_2.sv
// ---------------------------------------------------------------------------
// csa_row_3_2
// A W-bit row of full adders compressing three vectors into a sum vector and
// a carry vector. The carry vector is already weighted (shifted left by one,
// bit 0 = 0); the carry out of bit W-1 is dropped.
// Ports:
//   a, b, c : input  W-bit addends
//   s       : output W-bit bitwise sum
//   co      : output W-bit shifted carry
// ---------------------------------------------------------------------------
module csa_row_3_2
    import csa_pkg::*;
#(
    parameter int W = 16
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [W-1:0] c,
    output logic [W-1:0] s,
    output logic [W-1:0] co
);

    assign s  = a ^ b ^ c;
    assign co = ((a & b) | (a & c) | (b & c)) << 1;

endmodule

// File: rtl/csa_tree_pipe.sv
// ---------------------------------------------------------------------------
// csa_tree_pipe
// Pipelined multi-operand adder with optional running accumulation.
// NUM_OPS unsigned operands are reduced by Dadda-sequenced 3:2 carry-save
// levels (one register per level), then a carry-propagate adder feeds the
// output register, which also owns the accumulator. Latency is
// csa_levels(NUM_OPS)+1 cycles; one global stall freezes every stage.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   i_valid    : input beat valid
//   o_ready    : input beat accepted this cycle (when i_valid)
//   i_ops      : NUM_OPS operands, operand k at [k*WIDTH +: WIDTH]
//   i_acc      : beat adds into the running accumulator
//   i_clr      : beat clears the accumulator before its own addition
//   o_valid    : result valid
//   i_ready    : downstream accepts the result
//   o_sum      : result, OUT_W bits
// ---------------------------------------------------------------------------
module csa_tree_pipe
    import csa_pkg::*;
#(
    parameter  int NUM_OPS = 8,
    parameter  int WIDTH   = 16,
    parameter  int ACC_EXT = 8,
    localparam int OUT_W   = WIDTH + $clog2(NUM_OPS) + ACC_EXT
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_valid,
    output logic                     o_ready,
    input  logic [NUM_OPS*WIDTH-1:0] i_ops,
    input  logic                     i_acc,
    input  logic                     i_clr,
    output logic                     o_valid,
    input  logic                     i_ready,
    output logic [OUT_W-1:0]         o_sum
);

    localparam int LEVELS = csa_levels(NUM_OPS);

    // Single stall condition shared by every stage.
    logic advance;
    assign advance = !o_valid || i_ready;
    assign o_ready = advance;

    genvar gi, gj;
    generate
        for (gi = 0; gi < LEVELS; gi++) begin : g_lvl
            localparam int CIN  = dadda_height(NUM_OPS, gi);
            localparam int COUT = dadda_height(NUM_OPS, gi + 1);
            // Each 3:2 row removes exactly one operand from the stack.
            localparam int ROWS = CIN - COUT;

            logic [OUT_W-1:0] in_vec   [CIN];
            logic [OUT_W-1:0] vec_next [COUT];
            logic [OUT_W-1:0] vec_reg  [COUT];
            stage_tag_t       tag_in;
            stage_tag_t       tag_reg;

            if (gi == 0) begin : g_src
                for (gj = 0; gj < CIN; gj++) begin : g_op
                    assign in_vec[gj] = OUT_W'(i_ops[gj*WIDTH +: WIDTH]);
                end
                // The register only loads on advance, so i_valid here is
                // exactly the accepted-beat qualifier.
                assign tag_in = '{valid: i_valid, acc: i_acc, clr: i_clr};
            end else begin : g_chain
                for (gj = 0; gj < CIN; gj++) begin : g_op
                    assign in_vec[gj] = g_lvl[gi-1].vec_reg[gj];
                end
                assign tag_in = g_lvl[gi-1].tag_reg;
            end

            for (gj = 0; gj < ROWS; gj++) begin : g_row
                csa_row_3_2 #(
                    .W (OUT_W)
                ) u_row (
                    .a  (in_vec[3*gj]),
                    .b  (in_vec[3*gj+1]),
                    .c  (in_vec[3*gj+2]),
                    .s  (vec_next[2*gj]),
                    .co (vec_next[2*gj+1])
                );
            end

            // Operands not consumed by a row pass straight to the next level.
            for (gj = 0; gj < CIN - 3*ROWS; gj++) begin : g_pass
                assign vec_next[2*ROWS+gj] = in_vec[3*ROWS+gj];
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    tag_reg <= '0;
                    for (int k = 0; k < COUT; k++) begin
                        vec_reg[k] <= '0;
                    end
                end else if (advance) begin
                    tag_reg <= tag_in;
                    for (int k = 0; k < COUT; k++) begin
                        vec_reg[k] <= vec_next[k];
                    end
                end
            end
        end
    endgenerate

    // Carry-propagate stage feeding the output register.
    stage_tag_t       cpa_tag;
    logic [OUT_W-1:0] tree_sum;
    logic [OUT_W-1:0] acc_addend;
    logic [OUT_W-1:0] cpa_result;
    logic [OUT_W-1:0] acc_reg;

    assign cpa_tag    = g_lvl[LEVELS-1].tag_reg;
    assign tree_sum   = g_lvl[LEVELS-1].vec_reg[0] + g_lvl[LEVELS-1].vec_reg[1];
    assign acc_addend = (cpa_tag.acc && !cpa_tag.clr) ? acc_reg : '0;
    assign cpa_result = tree_sum + acc_addend;

    // acc_reg updates on the same edge a beat enters the output register, so a
    // back-to-back accumulate beat still in the CPA stage sees the new value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_valid <= 1'b0;
            o_sum   <= '0;
            acc_reg <= '0;
        end else if (advance) begin
            o_valid <= cpa_tag.valid;
            if (cpa_tag.valid) begin
                o_sum <= cpa_result;
                if (cpa_tag.acc) begin
                    acc_reg <= cpa_result;
                end else if (cpa_tag.clr) begin
                    acc_reg <= '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_csa_tree_pipe.sv
// ---------------------------------------------------------------------------
// tb_csa_tree_pipe
// Scoreboard bench: the acceptance monitor computes each beat's expected
// result from the operands it sees accepted and queues it; the output monitor
// pops and compares whenever a result is consumed. Extra instances with
// NUM_OPS 3, 5, 13, 16 check latency and sums with random operands.
// ---------------------------------------------------------------------------
module tb_csa_tree_pipe;

    localparam int N   = 8;
    localparam int W   = 16;
    localparam int AE  = 8;
    localparam int OW  = 27;
    localparam int LAT = 5;
    localparam logic [63:0] MASK = (64'd1 << OW) - 64'd1;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           i_valid = 1'b0;
    logic           o_ready;
    logic [N*W-1:0] i_ops = '0;
    logic           i_acc = 1'b0;
    logic           i_clr = 1'b0;
    logic           o_valid;
    logic           i_ready = 1'b1;
    logic [OW-1:0]  o_sum;

    csa_tree_pipe #(
        .NUM_OPS (N),
        .WIDTH   (W),
        .ACC_EXT (AE)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_valid (i_valid),
        .o_ready (o_ready),
        .i_ops   (i_ops),
        .i_acc   (i_acc),
        .i_clr   (i_clr),
        .o_valid (o_valid),
        .i_ready (i_ready),
        .o_sum   (o_sum)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    typedef struct {
        logic [63:0] sum;
        int          cyc;
    } exp_t;

    exp_t        exp_q [$];
    logic [63:0] got_q [$];
    int          out_cyc [$];
    logic [63:0] acc_m = '0;
    int          cyc = 0;
    bit          lat_chk = 1'b0;

    // Monitor: samples on the falling edge, where inputs and outputs are stable.
    initial begin : monitor
        bit          prev_stall;
        logic [OW-1:0] prev_sum;
        logic [63:0] tree;
        logic [63:0] res;
        exp_t        e;
        prev_stall = 1'b0;
        prev_sum   = '0;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst_n) begin
                check_val("o_ready", {63'd0, o_ready}, {63'd0, (!o_valid || i_ready)});
                if (prev_stall) begin
                    check_val("hold_valid", {63'd0, o_valid}, 64'd1);
                    check_val("hold_sum", 64'(o_sum), 64'(prev_sum));
                end
                if (i_valid && o_ready) begin
                    tree = '0;
                    for (int k = 0; k < N; k++) begin
                        tree = tree + 64'(i_ops[k*W +: W]);
                    end
                    if (i_acc && !i_clr) res = (tree + acc_m) & MASK;
                    else                 res = tree & MASK;
                    if (i_acc)      acc_m = res;
                    else if (i_clr) acc_m = '0;
                    e.sum = res;
                    e.cyc = cyc;
                    exp_q.push_back(e);
                end
                if (o_valid && i_ready) begin
                    if (exp_q.size() == 0) begin
                        check_val("spurious_out", 64'd1, 64'd0);
                    end else begin
                        e = exp_q.pop_front();
                        check_val("sum", 64'(o_sum), e.sum);
                        if (lat_chk) check_val("latency", 64'(cyc - e.cyc), 64'(LAT));
                        got_q.push_back(64'(o_sum));
                        out_cyc.push_back(cyc);
                    end
                end
                prev_stall = o_valid && !i_ready;
                prev_sum   = o_sum;
            end else begin
                prev_stall = 1'b0;
            end
        end
    end

    function automatic logic [N*W-1:0] fill(input logic [W-1:0] v);
        logic [N*W-1:0] r;
        for (int k = 0; k < N; k++) r[k*W +: W] = v;
        return r;
    endfunction

    // Called at posedge+1; returns at posedge+1 after the beat is accepted.
    task automatic send(input logic [N*W-1:0] ops, input logic acc, input logic clr);
        int guard;
        guard   = 0;
        i_ops   = ops;
        i_acc   = acc;
        i_clr   = clr;
        i_valid = 1'b1;
        @(negedge clk);
        while (!o_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (!o_ready) check_val("send_timeout", 64'd0, 64'd1);
        @(posedge clk);
        #1;
        i_valid = 1'b0;
        i_acc   = 1'b0;
        i_clr   = 1'b0;
    endtask

    task automatic drain();
        int g;
        g = 0;
        while (exp_q.size() != 0 && g < 300) begin
            @(posedge clk);
            #1;
            g++;
        end
        check_val("drain", 64'(exp_q.size()), 64'd0);
    endtask

    // Additional configurations: random operands, serial beats.
    localparam int SUB_N   [4] = '{3, 5, 13, 16};
    localparam int SUB_LAT [4] = '{2, 4, 6, 7};
    int sub_phase = 0;
    bit sub_done [4] = '{default: 1'b0};

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_sub
            localparam int SN = SUB_N[gi];
            localparam int SW = 16 + $clog2(SN) + 8;
            logic            s_valid = 1'b0;
            logic            s_oready;
            logic [SN*16-1:0] s_ops = '0;
            logic            s_acc = 1'b0;
            logic            s_clr = 1'b0;
            logic            s_ovalid;
            logic [SW-1:0]   s_sum;

            csa_tree_pipe #(
                .NUM_OPS (SN),
                .WIDTH   (16),
                .ACC_EXT (8)
            ) u_dut (
                .clk     (clk),
                .rst_n   (rst_n),
                .i_valid (s_valid),
                .o_ready (s_oready),
                .i_ops   (s_ops),
                .i_acc   (s_acc),
                .i_clr   (s_clr),
                .o_valid (s_ovalid),
                .i_ready (1'b1),
                .o_sum   (s_sum)
            );

            initial begin
                logic [63:0] m_acc;
                logic [63:0] tree;
                logic [63:0] res;
                logic [63:0] smask;
                int          lat;
                wait (sub_phase == gi + 1);
                m_acc = '0;
                smask = (64'd1 << SW) - 64'd1;
                @(posedge clk);
                #1;
                for (int b = 0; b < 6; b++) begin
                    tree = '0;
                    for (int k = 0; k < SN; k++) begin
                        s_ops[k*16 +: 16] = 16'($urandom);
                        tree = tree + 64'(s_ops[k*16 +: 16]);
                    end
                    s_clr = (b == 0);
                    s_acc = (b == 0) ? 1'b1 : 1'($urandom_range(0, 1));
                    if (s_acc && !s_clr) res = (tree + m_acc) & smask;
                    else                 res = tree & smask;
                    if (s_acc)      m_acc = res;
                    else if (s_clr) m_acc = '0;
                    s_valid = 1'b1;
                    check_val($sformatf("n%0d_ready", SN), {63'd0, s_oready}, 64'd1);
                    @(posedge clk);
                    #1;
                    s_valid = 1'b0;
                    lat = 1;
                    while (!s_ovalid && lat < 40) begin
                        @(posedge clk);
                        #1;
                        lat++;
                    end
                    check_val($sformatf("n%0d_latency", SN), 64'(lat), 64'(SUB_LAT[gi]));
                    check_val($sformatf("n%0d_sum", SN), 64'(s_sum), res);
                    @(posedge clk);
                    #1;
                end
                sub_done[gi] = 1'b1;
            end
        end
    endgenerate

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        logic [N*W-1:0] ops;
        int             n_before;
        int             g;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check_val("rst_o_valid", {63'd0, o_valid}, 64'd0);
        check_val("rst_o_sum", 64'(o_sum), 64'd0);
        rst_n = 1'b1;
        check_val("rst_o_ready", {63'd0, o_ready}, 64'd1);
        @(posedge clk);
        #1;

        // All operands max, plain sum, 5-cycle latency
        lat_chk = 1'b1;
        got_q.delete(); out_cyc.delete();
        send(fill(16'hFFFF), 1'b0, 1'b0);
        drain();
        check_val("max_sum_count", 64'(got_q.size()), 64'd1);
        if (got_q.size() > 0) check_val("max_sum", got_q[0], 64'd524280);

        // Three back-to-back accumulate beats of all ones
        got_q.delete(); out_cyc.delete();
        send(fill(16'd1), 1'b1, 1'b1);
        send(fill(16'd1), 1'b1, 1'b0);
        send(fill(16'd1), 1'b1, 1'b0);
        drain();
        check_val("acc3_count", 64'(got_q.size()), 64'd3);
        if (got_q.size() == 3) begin
            check_val("acc3_0", got_q[0], 64'd8);
            check_val("acc3_1", got_q[1], 64'd16);
            check_val("acc3_2", got_q[2], 64'd24);
            check_val("acc3_gap01", 64'(out_cyc[1] - out_cyc[0]), 64'd1);
            check_val("acc3_gap12", 64'(out_cyc[2] - out_cyc[1]), 64'd1);
        end

        // Ten-beat stream with a three-cycle downstream stall
        lat_chk = 1'b0;
        got_q.delete(); out_cyc.delete();
        fork
            begin
                for (int b = 0; b < 10; b++) begin
                    for (int k = 0; k < N; k++) ops[k*W +: W] = 16'($urandom);
                    send(ops, 1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0));
                end
            end
            begin
                repeat (7) @(posedge clk);
                #1;
                i_ready = 1'b0;
                repeat (3) @(posedge clk);
                #1;
                i_ready = 1'b1;
            end
        join
        drain();
        check_val("stream_count", 64'(got_q.size()), 64'd10);

        // 257 accumulate beats of all-max operands, wrap modulo 2^27
        lat_chk = 1'b1;
        got_q.delete(); out_cyc.delete();
        for (int b = 0; b < 257; b++) begin
            send(fill(16'hFFFF), 1'b1, (b == 0));
        end
        drain();
        check_val("wrap_count", 64'(got_q.size()), 64'd257);
        if (got_q.size() == 257) begin
            check_val("acc_256", got_q[255], 64'd134215680);
            check_val("acc_257", got_q[256], 64'd522232);
        end

        // Reset with three beats in flight
        send(fill(16'd1), 1'b1, 1'b0);
        send(fill(16'd1), 1'b1, 1'b0);
        send(fill(16'd1), 1'b1, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check_val("inflight_rst_o_valid", {63'd0, o_valid}, 64'd0);
        check_val("inflight_rst_o_sum", 64'(o_sum), 64'd0);
        exp_q.delete();
        acc_m = '0;
        got_q.delete(); out_cyc.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        check_val("post_rst_o_ready", {63'd0, o_ready}, 64'd1);
        n_before = got_q.size();
        repeat (12) @(posedge clk);
        #1;
        check_val("no_ghost_beats", 64'(got_q.size()), 64'(n_before));
        send(fill(16'd1), 1'b1, 1'b0);
        drain();
        check_val("post_rst_count", 64'(got_q.size()), 64'd1);
        if (got_q.size() > 0) check_val("post_rst_acc", got_q[0], 64'd8);

        // Other NUM_OPS configurations
        for (int p = 0; p < 4; p++) begin
            sub_phase = p + 1;
            g = 0;
            while (!sub_done[p] && g < 2000) begin
                @(posedge clk);
                #1;
                g++;
            end
            check_val($sformatf("sub%0d_done", p), {63'd0, sub_done[p]}, 64'd1);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
